// File: rtl/cbs_exec_stage.sv
// Execute stage: register-select mux, operand overrides, ALU and branch
// comparator, with every result registered for the memory/PC-update stage.
module cbs_exec_stage #(
  parameter  int unsigned NUM_REG    = 5,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned PC_WIDTH   = 4,
  localparam int unsigned REG_SELECT = (NUM_REG > 1) ? $clog2(NUM_REG) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic [NUM_REG*DATA_WIDTH-1:0] i_regs,
  input  logic [REG_SELECT-1:0]         i_select_a,
  input  logic [REG_SELECT-1:0]         i_select_b,
  input  logic [PC_WIDTH-1:0]           i_pc,
  input  logic [DATA_WIDTH-1:0]         i_offset,
  input  logic                          i_is_load,
  input  logic                          i_is_store,
  input  logic                          i_is_cmp,
  input  logic [3:0]                    i_alu_op,
  input  logic [2:0]                    i_cmp_op,
  output logic                          o_valid,
  output logic [DATA_WIDTH-1:0]         o_alu_data,
  output logic [DATA_WIDTH-1:0]         o_store_data,
  output logic                          o_taken
);

  localparam int unsigned SHAMT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] reg_a;
  logic [DATA_WIDTH-1:0] reg_b;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  cmp_res;

  logic                  valid_q,  valid_d;
  logic [DATA_WIDTH-1:0] alu_q,    alu_d;
  logic [DATA_WIDTH-1:0] store_q,  store_d;
  logic                  taken_q,  taken_d;

  // Source register mux; selects beyond the register count read as zero
  always_comb begin
    reg_a = '0;
    reg_b = '0;
    for (int unsigned k = 0; k < NUM_REG; k++) begin
      if (i_select_a == REG_SELECT'(k)) reg_a = i_regs[k*DATA_WIDTH +: DATA_WIDTH];
      if (i_select_b == REG_SELECT'(k)) reg_b = i_regs[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Branches compute pc+offset; memory ops compute base+offset
  always_comb begin
    op_a  = i_is_cmp ? DATA_WIDTH'(i_pc) : reg_a;
    op_b  = (i_is_load || i_is_store || i_is_cmp) ? i_offset : reg_b;
    shamt = op_b[SHAMT_W-1:0];
  end

  always_comb begin
    alu_res = '0;
    case (i_alu_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = DATA_WIDTH'($signed(op_a) < $signed(op_b));
      4'd9:    alu_res = DATA_WIDTH'(op_a < op_b);
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Comparator always sees the raw register operands, never the overrides
  always_comb begin
    cmp_res = 1'b0;
    case (i_cmp_op)
      3'd0:    cmp_res = (reg_a == reg_b);
      3'd1:    cmp_res = (reg_a != reg_b);
      3'd2:    cmp_res = ($signed(reg_a) <  $signed(reg_b));
      3'd3:    cmp_res = ($signed(reg_a) >= $signed(reg_b));
      3'd4:    cmp_res = (reg_a <  reg_b);
      3'd5:    cmp_res = (reg_a >= reg_b);
      default: cmp_res = 1'b0;
    endcase
  end

  // Bubbles clear valid/taken but leave the data registers untouched
  always_comb begin
    valid_d = i_valid;
    taken_d = i_valid & i_is_cmp & cmp_res;
    alu_d   = alu_q;
    store_d = store_q;
    if (i_valid) begin
      alu_d   = alu_res;
      store_d = reg_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      store_q <= '0;
      taken_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      taken_q <= taken_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_alu_data   = alu_q;
  assign o_store_data = store_q;
  assign o_taken      = taken_q;

endmodule

// File: tb/tb_cbs_exec_stage.sv
// Bench for cbs_exec_stage: directed corner cases plus randomized traffic
// checked against an arithmetic reference model of the stage.
module tb_cbs_exec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [159:0] i_regs;
  logic [2:0]  i_select_a, i_select_b;
  logic [3:0]  i_pc;
  logic [31:0] i_offset;
  logic        i_is_load, i_is_store, i_is_cmp;
  logic [3:0]  i_alu_op;
  logic [2:0]  i_cmp_op;
  logic        o_valid, o_taken;
  logic [31:0] o_alu_data, o_store_data;

  logic [31:0] regs_m [5];
  logic        exp_valid, exp_taken;
  logic [31:0] exp_alu, exp_store;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 5; k++) i_regs[k*32 +: 32] = regs_m[k];
  end

  cbs_exec_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_regs(i_regs),
    .i_select_a(i_select_a), .i_select_b(i_select_b), .i_pc(i_pc),
    .i_offset(i_offset), .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_is_cmp(i_is_cmp), .i_alu_op(i_alu_op), .i_cmp_op(i_cmp_op),
    .o_valid(o_valid), .o_alu_data(o_alu_data), .o_store_data(o_store_data),
    .o_taken(o_taken)
  );

  function automatic logic [31:0] rd(input logic [2:0] sel);
    return (sel < 3'd5) ? regs_m[sel] : 32'd0;
  endfunction

  // Reference: what the stage should produce for the current inputs
  task automatic model(output logic [31:0] alu, output logic [31:0] st, output logic tk);
    logic [31:0] ra, rb, a, b;
    int unsigned s;
    longint sa, sb;
    ra = rd(i_select_a);
    rb = rd(i_select_b);
    a  = i_is_cmp ? {28'd0, i_pc} : ra;
    b  = (i_is_load || i_is_store || i_is_cmp) ? i_offset : rb;
    s  = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (i_alu_op)
      4'd0: alu = a + b;
      4'd1: alu = a - b;
      4'd2: alu = a & b;
      4'd3: alu = a | b;
      4'd4: alu = a ^ b;
      4'd5: alu = a << s;
      4'd6: alu = a >> s;
      4'd7: alu = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      4'd8: alu = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: alu = (a < b) ? 32'd1 : 32'd0;
      4'd10: alu = b;
      default: alu = 32'd0;
    endcase
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    case (i_cmp_op)
      3'd0: tk = (ra == rb);
      3'd1: tk = (ra != rb);
      3'd2: tk = (sa < sb);
      3'd3: tk = (sa >= sb);
      3'd4: tk = (ra < rb);
      3'd5: tk = (ra >= rb);
      default: tk = 1'b0;
    endcase
    tk = tk & i_is_cmp;
    st = rb;
  endtask

  // Update expectations, then clock one edge and settle past it
  task automatic step();
    logic [31:0] a, s;
    logic t;
    model(a, s, t);
    exp_valid = i_valid;
    exp_taken = i_valid & t;
    if (i_valid) begin
      exp_alu   = a;
      exp_store = s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 1'b1; i_select_a = 3'd0; i_select_b = 3'd0; i_pc = 4'd0;
    i_offset = 32'd0; i_is_load = 1'b0; i_is_store = 1'b0; i_is_cmp = 1'b0;
    i_alu_op = 4'd0; i_cmp_op = 3'd6;
    for (int k = 0; k < 5; k++) regs_m[k] = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    exp_valid = 0; exp_taken = 0; exp_alu = 0; exp_store = 0;
    #1;
    checks++; if ({o_valid, o_taken, o_alu_data, o_store_data} !== 66'd0) begin failures++; $display("FAIL reset_state got v=%b t=%b alu=%h st=%h want all 0", o_valid, o_taken, o_alu_data, o_store_data); end
    regs_m[0] = 32'h55; i_select_b = 3'd0;
    @(posedge clk); #1;
    checks++; if ({o_valid, o_alu_data, o_store_data} !== 65'd0) begin failures++; $display("FAIL reset_hold got v=%b alu=%h st=%h want 0", o_valid, o_alu_data, o_store_data); end
    rst = 1'b1;
  endtask

  task automatic test_add();
    clear_inputs();
    regs_m[0] = 32'd1; regs_m[1] = 32'd2; i_select_a = 3'd1; i_select_b = 3'd0;
    step();
    checks++; if (o_alu_data !== 32'd3) begin failures++; $display("FAIL add_alu got=%h want=3", o_alu_data); end
    checks++; if (o_store_data !== 32'd1) begin failures++; $display("FAIL add_store got=%h want=1", o_store_data); end
    checks++; if ({o_valid, o_taken} !== 2'b10) begin failures++; $display("FAIL add_flags got v=%b t=%b want v=1 t=0", o_valid, o_taken); end
  endtask

  task automatic test_load();
    clear_inputs();
    regs_m[1] = 32'd2; i_select_b = 3'd1; i_is_load = 1'b1;
    step();
    checks++; if (o_alu_data !== 32'd0) begin failures++; $display("FAIL load_off0 got=%h want=0", o_alu_data); end
    i_offset = 32'd1;
    step();
    checks++; if (o_alu_data !== 32'd1) begin failures++; $display("FAIL load_off1 got=%h want=1", o_alu_data); end
    checks++; if (o_store_data !== 32'd2) begin failures++; $display("FAIL load_store got=%h want=2", o_store_data); end
  endtask

  task automatic test_branch();
    clear_inputs();
    regs_m[2] = 32'd3; regs_m[3] = 32'd4; i_is_cmp = 1'b1; i_pc = 4'd5;
    i_offset = 32'd1; i_cmp_op = 3'd0; i_select_a = 3'd2; i_select_b = 3'd2;
    step();
    checks++; if (o_alu_data !== 32'd6) begin failures++; $display("FAIL br_target got=%h want=6", o_alu_data); end
    checks++; if (o_taken !== 1'b1) begin failures++; $display("FAIL br_taken got=%b want=1", o_taken); end
    i_select_b = 3'd3;
    step();
    checks++; if ({o_taken, o_alu_data} !== {1'b0, 32'd6}) begin failures++; $display("FAIL br_not_taken got t=%b alu=%h want t=0 alu=6", o_taken, o_alu_data); end
    // Compare true but not a compare instruction: never taken
    i_is_cmp = 1'b0; i_select_b = 3'd2;
    step();
    checks++; if (o_taken !== 1'b0) begin failures++; $display("FAIL br_noncmp got=%b want=0", o_taken); end
  endtask

  task automatic test_arith();
    clear_inputs();
    regs_m[0] = 32'd0; regs_m[1] = 32'd1; i_select_a = 3'd0; i_select_b = 3'd1;
    i_alu_op = 4'd1; step();
    checks++; if (o_alu_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sub_wrap got=%h want=ffffffff", o_alu_data); end
    regs_m[0] = 32'hFFFF_FFFF;
    i_alu_op = 4'd8; step();
    checks++; if (o_alu_data !== 32'd1) begin failures++; $display("FAIL slt got=%h want=1", o_alu_data); end
    i_alu_op = 4'd9; step();
    checks++; if (o_alu_data !== 32'd0) begin failures++; $display("FAIL sltu got=%h want=0", o_alu_data); end
    regs_m[0] = 32'h8000_0000; regs_m[1] = 32'd4;
    i_alu_op = 4'd7; step();
    checks++; if (o_alu_data !== 32'hF800_0000) begin failures++; $display("FAIL sra got=%h want=f8000000", o_alu_data); end
    regs_m[0] = 32'd3; regs_m[1] = 32'd33;
    i_alu_op = 4'd5; step();
    checks++; if (o_alu_data !== 32'd6) begin failures++; $display("FAIL sll33 got=%h want=6", o_alu_data); end
  endtask

  task automatic test_mux_bounds();
    clear_inputs();
    regs_m[1] = 32'd7; i_select_a = 3'd6; i_select_b = 3'd1;
    step();
    checks++; if (o_alu_data !== 32'd7) begin failures++; $display("FAIL mux_sel6 got=%h want=7", o_alu_data); end
    i_select_a = 3'd1; i_select_b = 3'd5;
    step();
    checks++; if ({o_alu_data, o_store_data} !== {32'd7, 32'd0}) begin failures++; $display("FAIL mux_sel5 got alu=%h st=%h want 7/0", o_alu_data, o_store_data); end
  endtask

  task automatic test_bubble();
    clear_inputs();
    regs_m[2] = 32'd9; i_select_a = 3'd2; i_select_b = 3'd2; i_alu_op = 4'd0;
    step();
    i_valid = 1'b0; i_is_cmp = 1'b1; i_cmp_op = 3'd0; i_select_a = 3'd0; i_select_b = 3'd1;
    regs_m[1] = 32'd0;
    step();
    checks++; if ({o_valid, o_taken} !== 2'b00) begin failures++; $display("FAIL bubble_flags got v=%b t=%b want 0/0", o_valid, o_taken); end
    checks++; if ({o_alu_data, o_store_data} !== {32'd18, 32'd9}) begin failures++; $display("FAIL bubble_hold got alu=%h st=%h want 12/9", o_alu_data, o_store_data); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    regs_m[0] = 32'hA5; i_alu_op = 4'd3;
    step();
    #2 rst = 1'b0;
    #1;
    checks++; if ({o_valid, o_taken, o_alu_data, o_store_data} !== 66'd0) begin failures++; $display("FAIL rst_async got v=%b alu=%h st=%h want 0", o_valid, o_alu_data, o_store_data); end
    @(posedge clk); #1;
    checks++; if ({o_valid, o_alu_data, o_store_data} !== 65'd0) begin failures++; $display("FAIL rst_held got v=%b alu=%h want 0", o_valid, o_alu_data); end
    rst = 1'b1;
    exp_valid = 0; exp_taken = 0; exp_alu = 0; exp_store = 0;
    regs_m[0] = 32'd21; i_alu_op = 4'd0;
    step();
    checks++; if ({o_valid, o_alu_data, o_store_data} !== {1'b1, 32'd42, 32'd21}) begin failures++; $display("FAIL rst_release got v=%b alu=%h st=%h want 1/2a/15", o_valid, o_alu_data, o_store_data); end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      int cls;
      for (int k = 0; k < 5; k++) regs_m[k] = rnd_word();
      i_valid    = ($urandom_range(0, 7) != 0);
      i_select_a = 3'($urandom_range(0, 7));
      i_select_b = ($urandom_range(0, 3) == 0) ? i_select_a : 3'($urandom_range(0, 7));
      i_pc       = 4'($urandom);
      i_offset   = rnd_word();
      cls        = $urandom_range(0, 3);
      i_is_load  = (cls == 1); i_is_store = (cls == 2); i_is_cmp = (cls == 3);
      i_alu_op   = 4'($urandom);
      i_cmp_op   = 3'($urandom);
      step();
      checks++; if ({o_valid, o_taken} !== {exp_valid, exp_taken}) begin failures++; $display("FAIL rand_flags[%0d] got v=%b t=%b want v=%b t=%b", n, o_valid, o_taken, exp_valid, exp_taken); end
      checks++; if (o_alu_data !== exp_alu) begin failures++; $display("FAIL rand_alu[%0d] op=%0d got=%h want=%h", n, i_alu_op, o_alu_data, exp_alu); end
      checks++; if (o_store_data !== exp_store) begin failures++; $display("FAIL rand_store[%0d] got=%h want=%h", n, o_store_data, exp_store); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_branch();
    test_arith();
    test_mux_bounds();
    test_bubble();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
